// File: rtl/aes_mix_columns_seq.sv
// aes_mix_columns_seq: AES (Inv)MixColumns over a 128-bit state, COLS_PER_CYCLE columns per cycle
module aes_mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);
  localparam int NCYC = 4 / COLS_PER_CYCLE;
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t       r_state;
  logic [1:0]   r_cnt;
  logic         r_inv;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [127:0] r_data;
  logic [127:0] w_next;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] mix(input logic [31:0] col, input logic inv);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x4, x8;
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      m2[r] = xt(a[r]);
      x4    = xt(m2[r]);
      x8    = xt(x4);
      m3[r] = m2[r] ^ a[r];
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ m2[r] ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ m2[r];
    end
    for (int r = 0; r < 4; r++)
      mix[31-8*r -: 8] = inv ? me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4]
                             : m2[r] ^ m3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
  endfunction
  function automatic logic [127:0] step(input logic [127:0] d, input logic [1:0] cnt, input logic inv);
    logic [1:0] c;
    step = d;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      c = 2'(int'(cnt) * COLS_PER_CYCLE + k);
      step[127-32*c -: 32] = mix(d[127-32*c -: 32], inv);
    end
  endfunction
  always_comb w_next = step(r_data, r_cnt, r_inv);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_inv       <= 1'b0;
      r_data      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_data     <= in_state;
          r_inv      <= in_inv;
          r_cnt      <= '0;
          r_in_ready <= 1'b0;
          r_state    <= BUSY;
        end
        BUSY: begin
          r_data <= w_next;
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'(NCYC - 1)) begin
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_state = r_data;
endmodule

// File: doc/aes_mix_columns_seq.md
AES_MIX_COLUMNS_SEQ -- requirements
Module: aes_mix_columns_seq

Interface
REQ-001 Parameter: COLS_PER_CYCLE, default 1, columns transformed per BUSY cycle; legal values 1, 2, 4.
REQ-002 Derived constant: NCYC = 4/COLS_PER_CYCLE, BUSY cycles per block.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream offers a block.
REQ-006 in_ready  output  1  block may accept an input this cycle.
REQ-007 in_inv  input  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_state.
REQ-008 in_state  input  128  AES state; byte i = in_state[127-8i -: 8]; column c = bytes 4c..4c+3, row 0 first.
REQ-009 out_valid  output  1  out_state holds a completed result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_state  output  128  transformed state; same byte ordering as in_state.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both are registered or decoded from state only, with no combinational path from inputs.
REQ-014 IDLE: on in_valid=1, SHALL capture in_state and in_inv, clear the column counter, and go to BUSY.
REQ-015 BUSY: each cycle SHALL replace COLS_PER_CYCLE columns, in ascending column order, with their transform, then advance the counter.
REQ-016 After the NCYC-th BUSY cycle the FSM SHALL go to DONE; out_valid therefore rises NCYC cycles after the accepting edge.
REQ-017 DONE: out_state and out_valid SHALL hold stable while out_ready=0; on out_ready=1 the FSM SHALL go to IDLE at that edge.
REQ-018 Throughput: one block per NCYC+2 cycles with out_ready tied high.
REQ-019 Forward transform per column (a0..a3 -> b0..b3): b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
REQ-020 Inverse transform SHALL use coefficient rows {0e,0b,0d,09} rotated identically.
REQ-021 All products SHALL be GF(2^8) multiplications modulo x^8+x^4+x^3+x+1 (xtime reduction constant 8'h1b), built from xtime chains; no lookup ROM.
REQ-022 The latched mode SHALL apply to the whole block; changes to in_inv or in_state after acceptance SHALL have no effect.
REQ-023 in_valid while in BUSY or DONE SHALL be ignored; the upstream holds it until in_ready=1.
REQ-024 out_ready while not in DONE SHALL be ignored.
REQ-025 out_state is don't-care while out_valid=0.
REQ-026 A COLS_PER_CYCLE value outside {1,2,4} SHALL fail elaboration.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, counter=0, out_valid=0, out_state=128'h0, and latched mode=0; in_ready=1 after reset.
REQ-028 Reset asserted in BUSY or DONE SHALL abort the block with no output produced; the first post-reset acceptance SHALL behave as after power-up.
REQ-029 Deassertion need not be synchronised internally; upstream guarantees it meets recovery timing.

Verification
REQ-030 Forward: in_state=db135345_f20a225c_01010101_c6c6c6c6, in_inv=0 -> out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid rising exactly NCYC cycles after acceptance, for each of COLS_PER_CYCLE=1, 2 and 4.
REQ-031 Inverse: in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, in_inv=1 -> out_state=db135345_f20a225c_01010101_c6c6c6c6; also d4d4d4d5_2d26314c inverse-round-trips through the forward transform (d5d5d7d6_4d7ebdf8).
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_state and out_valid stable and in_ready=0 throughout; first out_ready=1 edge -> IDLE, in_ready=1 next cycle.
REQ-033 Mode/data change mid-block: toggle in_inv and randomise in_state during BUSY -> result matches the values latched at acceptance.
REQ-034 Reset mid-BUSY (COLS_PER_CYCLE=1, after 2 BUSY cycles) -> out_valid=0, out_state=0 and in_ready=1 immediately; the next block completes correctly.
REQ-035 Random regression: 10k random states and modes with random valid/ready gaps -> matches reference model; inverse(forward(x))=x.
